cla_nibble_seq: RTL and testbench

CLA_NIBBLE_SEQ -- requirements
Module: cla_nibble_seq

---
 rtl/cla_nibble_seq.sv | 154 +++++++++++++++
 tb/tb_cla_nibble_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_seq.sv
// rtl/cla_nibble_seq.sv - 16-bit add/subtract on one time-shared 4-bit CLA
// Nibble 0 is processed first; results become visible only on the RUN->DONE edge.

module cla_4bit (
    input  logic       carry_start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sum,
    output logic       carry_out
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = carry_start;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum       = p ^ c[3:0];
        carry_out = c[4];
    end
endmodule

module cla_nibble_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    input  logic        carry_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum,
    output logic        carry_out,
    output logic        overflow
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic [15:0] acc_q, acc_d;
    logic        carry_q, carry_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] sum_q, sum_d;
    logic        carry_out_q, carry_out_d;
    logic        overflow_q, overflow_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [3:0]  nib_sum;
    logic        nib_co;

    assign nib_a = op_a_q[{idx_q, 2'b00} +: 4];
    assign nib_b = op_b_q[{idx_q, 2'b00} +: 4];

    cla_4bit u_cla (
        .carry_start (carry_q),
        .a           (nib_a),
        .b           (nib_b),
        .sum         (nib_sum),
        .carry_out   (nib_co)
    );

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : carry_in;
                    idx_d   = 2'd0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d[{idx_q, 2'b00} +: 4] = nib_sum;
                carry_d = nib_co;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    // Final nibble bypasses the accumulator so outputs load in this same edge.
                    sum_d       = {nib_sum, acc_q[11:0]};
                    carry_out_d = nib_co;
                    overflow_d  = (op_a_q[15] == op_b_q[15]) && (nib_sum[3] != op_a_q[15]);
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_a_q      <= 16'h0000;
            op_b_q      <= 16'h0000;
            acc_q       <= 16'h0000;
            carry_q     <= 1'b0;
            idx_q       <= 2'd0;
            sum_q       <= 16'h0000;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_cla_nibble_seq.sv
// tb/tb_cla_nibble_seq.sv - self-checking bench for cla_nibble_seq
// Vector table, random operations against an arithmetic model, and handshake/reset sequences.

module tb_cla_nibble_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        carry_in;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        carry_out;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    cla_nibble_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vsub;
        logic        vcin;
        logic [15:0] esum;
        logic        eco;
        logic        eov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned for carry/borrow, signed range for overflow.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic ms, input logic mc,
                         output logic [15:0] rs, output logic rco, output logic rov);
        int ua, ub, ur, sa, sb, sr;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (ms) begin
            ur  = ua - ub;
            sr  = sa - sb;
            rco = (ua >= ub);
        end else begin
            ur  = ua + ub + int'(mc);
            sr  = sa + sb + int'(mc);
            rco = (ur > 65535);
        end
        rs  = ur[15:0];
        rov = (sr > 32767) || (sr < -32768);
    endtask

    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic ts, input logic tc);
        logic [15:0] es;
        logic        eco, eov;
        int          n;
        model(ta, tb_, ts, tc, es, eco, eov);
        @(negedge clk);
        a = ta; b = tb_; sub = ts; carry_in = tc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, " busy_after_accept"}, busy, 1);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); carry_in = 1'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, n, 4);
        chk({tag, " sum"}, sum, es);
        chk({tag, " carry_out"}, carry_out, eco);
        chk({tag, " overflow"}, overflow, eov);
        @(posedge clk);
        #1;
        chk({tag, " done_one_cycle"}, done, 0);
        chk({tag, " idle_busy"}, busy, 0);
        chk({tag, " sum_held"}, sum, es);
    endtask

    vec_t vecs[6];
    int   ndone;
    int   dtimes[$];
    logic [15:0] es;
    logic        eco, eov;

    initial begin
        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; sub = 1'b0; carry_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset sum", sum, 16'h0000);
        chk("reset carry_out", carry_out, 0);
        chk("reset overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vsub, vecs[i].vcin);
            chk($sformatf("vec%0d table_sum", i), sum, vecs[i].esum);
            chk($sformatf("vec%0d table_co", i), carry_out, vecs[i].eco);
            chk($sformatf("vec%0d table_ov", i), overflow, vecs[i].eov);
        end

        for (int i = 0; i < 25; i++)
            run_op($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

        // start pulses in RUN and in DONE must be ignored
        @(negedge clk);
        a = 16'h00FF; b = 16'h0101; sub = 1'b0; carry_in = 1'b0; start = 1'b1;
        @(posedge clk);
        ndone = 0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            start = (j == 2 || j == 5);
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("pulse_ignored done_count", ndone, 1);
        chk("pulse_ignored sum", sum, 16'h0200);
        chk("pulse_ignored idle", busy, 0);

        // held start: done every 6 cycles
        @(negedge clk);
        a = 16'hA5A5; b = 16'h1111; sub = 1'b1; carry_in = 1'b0; start = 1'b1;
        model(16'hA5A5, 16'h1111, 1'b1, 1'b0, es, eco, eov);
        @(posedge clk);
        for (int j = 1; j <= 19; j++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dtimes.push_back(j);
                chk($sformatf("held sum@%0d", j), sum, es);
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("held done_count", dtimes.size(), 3);
        if (dtimes.size() == 3) begin
            chk("held first_done", dtimes[0], 4);
            chk("held interval1", dtimes[1] - dtimes[0], 6);
            chk("held interval2", dtimes[2] - dtimes[1], 6);
        end
        begin
            int guard = 0;
            while ((busy || done) && guard < 20) begin
                @(posedge clk);
                #1;
                guard++;
            end
            chk("held drain", guard < 20, 1);
        end

        // reset in the 2nd RUN cycle aborts with no done
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; sub = 1'b0; carry_in = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort sum", sum, 16'h0000);
        chk("abort carry_out", carry_out, 0);
        chk("abort overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("abort no_done", ndone, 0);

        run_op("post_abort", 16'h7FFF, 16'h8000, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
